// File: rtl/bpred_unit_if.sv
// Fetch-side prediction and EX-side resolution signals of the branch predictor.
// The slave modport is the predictor; the master modport is the pipeline driving it.
interface bpred_unit_if #(
   parameter int GHR_BITS = 8,
   parameter int CNT_W    = 16
);
   logic [31:0]         pc_f;
   logic                fetch_en;
   logic                pred_taken;
   logic [31:0]         pred_target;
   logic [31:0]         pred_next_pc;
   logic                btb_hit;
   logic [GHR_BITS-1:0] pred_ghr;

   logic                upd_valid;
   logic                upd_is_branch;
   logic [31:0]         upd_pc;
   logic                upd_taken;
   logic [31:0]         upd_target;
   logic                upd_pred_taken;
   logic [31:0]         upd_pred_target;
   logic [GHR_BITS-1:0] upd_ghr;
   logic                mispredict;
   logic [31:0]         redirect_pc;
   logic [CNT_W-1:0]    br_count;
   logic [CNT_W-1:0]    mis_count;

   modport slave (
      input  pc_f, fetch_en,
      input  upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
      input  upd_pred_taken, upd_pred_target, upd_ghr,
      output pred_taken, pred_target, pred_next_pc, btb_hit, pred_ghr,
      output mispredict, redirect_pc, br_count, mis_count
   );

   modport master (
      output pc_f, fetch_en,
      output upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target,
      output upd_pred_taken, upd_pred_target, upd_ghr,
      input  pred_taken, pred_target, pred_next_pc, btb_hit, pred_ghr,
      input  mispredict, redirect_pc, br_count, mis_count
   );
endinterface

// File: rtl/bpred_unit.sv
// Direct-mapped BTB plus 2-bit bimodal/gshare direction table with global history,
// speculative history shift at fetch and history recovery on mispredict.
module bpred_unit #(
   parameter int BTB_ENTRIES = 64,
   parameter int BHT_ENTRIES = 256,
   parameter int GHR_BITS    = 8,
   parameter int MODE        = 1,
   parameter int CNT_W       = 16
) (
   input logic         clk,
   input logic         rst,
   bpred_unit_if.slave bp
);
   localparam int IB = $clog2(BTB_ENTRIES);
   localparam int HB = $clog2(BHT_ENTRIES);
   localparam int TW = 30 - IB;

   logic                btb_valid_q [BTB_ENTRIES];
   logic                btb_valid_d [BTB_ENTRIES];
   logic [TW-1:0]       btb_tag_q   [BTB_ENTRIES];
   logic [TW-1:0]       btb_tag_d   [BTB_ENTRIES];
   logic [31:0]         btb_tgt_q   [BTB_ENTRIES];
   logic [31:0]         btb_tgt_d   [BTB_ENTRIES];
   logic [1:0]          bht_q       [BHT_ENTRIES];
   logic [1:0]          bht_d       [BHT_ENTRIES];
   logic [GHR_BITS-1:0] ghr_q, ghr_d;
   logic [CNT_W-1:0]    br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0]    mis_cnt_q, mis_cnt_d;

   logic [IB-1:0]       f_bidx, u_bidx;
   logic [TW-1:0]       f_tag;
   logic [HB-1:0]       f_hidx, u_hidx;
   logic                btb_hit, pred_taken;
   logic                br_upd, alias_hit;
   logic                mispredict;
   logic [31:0]         upd_pc4, redirect_pc;

   always_comb begin
      f_bidx = bp.pc_f[IB+1:2];
      f_tag  = bp.pc_f[31:IB+2];
      u_bidx = bp.upd_pc[IB+1:2];
      f_hidx = bp.pc_f[HB+1:2];
      u_hidx = bp.upd_pc[HB+1:2];
      if (MODE == 1) begin
         f_hidx = f_hidx ^ HB'(ghr_q);
         u_hidx = u_hidx ^ HB'(bp.upd_ghr);
      end
      btb_hit    = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
      pred_taken = btb_hit & bht_q[f_hidx][1];
   end

   assign bp.btb_hit      = btb_hit;
   assign bp.pred_taken   = pred_taken;
   assign bp.pred_target  = btb_hit ? btb_tgt_q[f_bidx] : 32'd0;
   assign bp.pred_next_pc = pred_taken ? btb_tgt_q[f_bidx] : bp.pc_f + 32'd4;
   assign bp.pred_ghr     = ghr_q;

   // A non-branch that fetch predicted taken hit a stale/aliased BTB entry.
   always_comb begin
      br_upd      = bp.upd_valid & bp.upd_is_branch;
      alias_hit   = bp.upd_valid & ~bp.upd_is_branch & bp.upd_pred_taken;
      upd_pc4     = bp.upd_pc + 32'd4;
      mispredict  = 1'b0;
      redirect_pc = 32'd0;
      if (alias_hit) begin
         mispredict  = 1'b1;
         redirect_pc = upd_pc4;
      end else if (bp.upd_valid) begin
         mispredict  = (bp.upd_taken != bp.upd_pred_taken) |
                       (bp.upd_taken & (bp.upd_target != bp.upd_pred_target));
         redirect_pc = bp.upd_taken ? bp.upd_target : upd_pc4;
      end
   end

   assign bp.mispredict  = mispredict;
   assign bp.redirect_pc = redirect_pc;
   assign bp.br_count    = br_cnt_q;
   assign bp.mis_count   = mis_cnt_q;

   always_comb begin
      btb_valid_d = btb_valid_q;
      btb_tag_d   = btb_tag_q;
      btb_tgt_d   = btb_tgt_q;
      bht_d       = bht_q;
      if (br_upd) begin
         if (bp.upd_taken) begin
            btb_valid_d[u_bidx] = 1'b1;
            btb_tag_d[u_bidx]   = bp.upd_pc[31:IB+2];
            btb_tgt_d[u_bidx]   = bp.upd_target;
            if (bht_q[u_hidx] != 2'b11) bht_d[u_hidx] = bht_q[u_hidx] + 2'd1;
         end else if (bht_q[u_hidx] != 2'b00) begin
            bht_d[u_hidx] = bht_q[u_hidx] - 2'd1;
         end
      end else if (alias_hit) begin
         btb_valid_d[u_bidx] = 1'b0;
      end
   end

   // Recovery from the resolved snapshot overrides the speculative fetch shift.
   always_comb begin
      ghr_d = ghr_q;
      if (mispredict) begin
         ghr_d = bp.upd_is_branch ? GHR_BITS'({bp.upd_ghr, bp.upd_taken}) : bp.upd_ghr;
      end else if (bp.fetch_en & btb_hit) begin
         ghr_d = GHR_BITS'({ghr_q, pred_taken});
      end
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (br_upd && (br_cnt_q != '1))      br_cnt_d  = br_cnt_q + 1'b1;
      if (mispredict && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid_q[i] <= 1'b0;
            btb_tag_q[i]   <= '0;
            btb_tgt_q[i]   <= '0;
         end
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
         ghr_q     <= '0;
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         btb_valid_q <= btb_valid_d;
         btb_tag_q   <= btb_tag_d;
         btb_tgt_q   <= btb_tgt_d;
         bht_q       <= bht_d;
         ghr_q       <= ghr_d;
         br_cnt_q    <= br_cnt_d;
         mis_cnt_q   <= mis_cnt_d;
      end
   end
endmodule
